// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the serial convolution engine.
// Optional build macro CONV_ZERO_SKIP_EN is consumed by conv_serial_mult.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_TAPS   = 9;
    localparam int DEF_DW     = 8;
    localparam int DEF_KW     = 8;
    localparam int DEF_PERF_W = 32;

    // Wide enough for TAPS full-scale signed products without overflow.
    function automatic int acc_width(input int taps, input int dw, input int kw);
        return dw + kw + $clog2(taps);
    endfunction

endpackage

// File: rtl/conv_serial_mult.sv
// One-tap signed bit-serial multiply-accumulate step (one weight bit per cycle).
// Build macro CONV_ZERO_SKIP_EN: a zero weight finishes its tap in a single step.
module conv_serial_mult
    import conv_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int KW    = DEF_KW,
    parameter int ACC_W = acc_width(DEF_TAPS, DEF_DW, DEF_KW)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             clear,
    input  logic             step,
    input  logic [DW-1:0]    x,
    input  logic [KW-1:0]    k,
    output logic             tap_done,
    output logic [ACC_W-1:0] acc_next
);

    localparam int BW = $clog2(KW);

    logic [BW-1:0]    bit_idx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] x_ext;
    logic [ACC_W-1:0] term;
    logic             last_bit;
    logic             zero_tap;

    // The weight's top bit carries negative weight in two's complement, so it subtracts.
    always_comb begin
        x_ext    = {{(ACC_W-DW){x[DW-1]}}, x};
        term     = x_ext << bit_idx;
        last_bit = (bit_idx == BW'(KW-1));
`ifdef CONV_ZERO_SKIP_EN
        zero_tap = (k == '0);
`else
        zero_tap = 1'b0;
`endif
        tap_done = last_bit || zero_tap;
        acc_next = acc;
        if (!zero_tap && k[bit_idx]) begin
            acc_next = last_bit ? (acc - term) : (acc + term);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            acc     <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            acc     <= '0;
            bit_idx <= '0;
        end else if (step) begin
            acc     <= acc_next;
            bit_idx <= tap_done ? '0 : bit_idx + BW'(1);
        end
    end

endmodule

// File: rtl/conv_serial_engine.sv
// TAPS-wide signed dot product using a bit-serial MAC, with result backpressure and perf counters.
// Optional build macro CONV_ZERO_SKIP_EN (zero-weight taps take one cycle) lives in conv_serial_mult.
module conv_serial_engine
    import conv_pkg::*;
#(
    parameter int TAPS   = DEF_TAPS,
    parameter int DW     = DEF_DW,
    parameter int KW     = DEF_KW,
    parameter int ACC_W  = acc_width(TAPS, DW, KW),
    parameter int PERF_W = DEF_PERF_W
) (
    input  logic               i_clk,
    input  logic               i_arstn,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [TAPS*DW-1:0] i_x,
    input  logic [TAPS*KW-1:0] i_k,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ACC_W-1:0]   o_conv,
    input  logic               i_perf_clr,
    output logic [PERF_W-1:0]  o_perf_cycle_count,
    output logic [PERF_W-1:0]  o_perf_op_count
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [TAPS*DW-1:0] x_q;
    logic [TAPS*KW-1:0] k_q;
    logic [TW-1:0]      tap_q;
    logic [PERF_W-1:0]  busy_q;
    logic [DW-1:0]      cur_x;
    logic [KW-1:0]      cur_k;
    logic [ACC_W-1:0]   acc_next;
    logic               tap_done;
    logic               accept;
    logic               step;
    logic               last_step;
    logic               handshake;

    assign cur_x = x_q[tap_q*DW +: DW];
    assign cur_k = k_q[tap_q*KW +: KW];

    conv_serial_mult #(
        .DW    (DW),
        .KW    (KW),
        .ACC_W (ACC_W)
    ) u_mult (
        .clk      (i_clk),
        .arstn    (i_arstn),
        .clear    (accept),
        .step     (step),
        .x        (cur_x),
        .k        (cur_k),
        .tap_done (tap_done),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d   = state_q;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                step = 1'b1;
                if (tap_done && (tap_q == TW'(TAPS-1))) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured on accept so the host may change them while we compute.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= IDLE;
            x_q     <= '0;
            k_q     <= '0;
            tap_q   <= '0;
            busy_q  <= '0;
            o_conv  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q    <= i_x;
                k_q    <= i_k;
                tap_q  <= '0;
                busy_q <= '0;
            end
            if (step) begin
                busy_q <= busy_q + PERF_W'(1);
                if (tap_done && !last_step) begin
                    tap_q <= tap_q + TW'(1);
                end
            end
            if (last_step) begin
                o_conv <= acc_next;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            o_perf_cycle_count <= '0;
            o_perf_op_count    <= '0;
        end else if (i_perf_clr) begin
            o_perf_cycle_count <= '0;
            o_perf_op_count    <= '0;
        end else begin
            if (last_step) begin
                o_perf_cycle_count <= busy_q + PERF_W'(1);
            end
            if (handshake) begin
                o_perf_op_count <= o_perf_op_count + PERF_W'(1);
            end
        end
    end

endmodule
